// File: rtl/vending_pkg.sv
// Shared types and constants for the vending datapath: dispenser states, fault codes, coin values.
package vending_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StEject1,
        StEject2,
        StWaitRel,
        StFaultEmpty,
        StFaultTo
    } disp_state_e;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'b00,
        FLT_EMPTY   = 2'b01,
        FLT_TIMEOUT = 2'b10
    } fault_e;

    localparam int unsigned COIN1_VAL = 1;
    localparam int unsigned COIN2_VAL = 2;
    localparam int unsigned OWED_MAX  = 15;

    function automatic logic [3:0] sat_owed(input logic [4:0] v);
        return (v > 5'(OWED_MAX)) ? 4'(OWED_MAX) : v[3:0];
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Vending-side inputs, hopper handshake and status outputs of the change dispenser.
interface change_dispenser_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pdt_i;
    logic [2:0]       cng_i;
    logic [2:0]       rtn_i;
    logic             hopper_ack;
    logic             refill;
    logic             clear_fault;
    logic             eject1;
    logic             eject2;
    logic             busy;
    logic [3:0]       owed;
    logic [1:0]       fault;
    logic [CNT_W-1:0] c1_level;
    logic [CNT_W-1:0] c2_level;

    modport master (
        output pdt_i, cng_i, rtn_i, hopper_ack, refill, clear_fault,
        input  eject1, eject2, busy, owed, fault, c1_level, c2_level
    );

    modport slave (
        input  pdt_i, cng_i, rtn_i, hopper_ack, refill, clear_fault,
        output eject1, eject2, busy, owed, fault, c1_level, c2_level
    );
endinterface

// File: rtl/dispense_event_capture.sv
// Detects change/refund events and keeps the saturating owed accumulator, net of coins paid.
module dispense_event_capture
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pdt,
    input  logic [2:0] cng,
    input  logic [2:0] rtn,
    input  logic [1:0] paid,
    output logic [3:0] owed
);
    logic       pdt_q;
    logic       rtn_nz_q;
    logic [3:0] owed_q;
    logic [3:0] owed_d;
    logic       chg_evt;
    logic       rfd_evt;
    logic [4:0] added;
    logic [4:0] total;

    always_comb begin
        chg_evt = pdt && !pdt_q && (cng != 3'd0);
        rfd_evt = (rtn != 3'd0) && !rtn_nz_q;
        added   = 5'd0;
        if (chg_evt) added = added + {2'b00, cng};
        if (rfd_evt) added = added + {2'b00, rtn};
        // paid never exceeds owed_q, so the subtraction cannot wrap
        total  = {1'b0, owed_q} - {3'b000, paid} + added;
        owed_d = sat_owed(total);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pdt_q    <= 1'b0;
            rtn_nz_q <= 1'b0;
            owed_q   <= 4'd0;
        end else begin
            pdt_q    <= pdt;
            rtn_nz_q <= (rtn != 3'd0);
            owed_q   <= owed_d;
        end
    end

    assign owed = owed_q;

endmodule

// File: rtl/change_dispenser.sv
// Pays owed change/refunds through a two-tube hopper, one coin per request/ack handshake.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned INIT_C1     = 20,
    parameter int unsigned INIT_C2     = 20,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    change_dispenser_if.slave bus
);
    localparam int unsigned      TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] INIT1    = CNT_W'(INIT_C1);
    localparam logic [CNT_W-1:0] INIT2    = CNT_W'(INIT_C2);

    disp_state_e      state_q;
    fault_e           fault_q;
    logic             eject1_q;
    logic             eject2_q;
    logic [CNT_W-1:0] c1_q;
    logic [CNT_W-1:0] c2_q;
    logic [TMO_W-1:0] tmo_q;
    logic [3:0]       owed;
    logic             ack_take;
    logic [1:0]       paid;

    dispense_event_capture u_capture (
        .clk  (clk),
        .rst  (rst),
        .pdt  (bus.pdt_i),
        .cng  (bus.cng_i),
        .rtn  (bus.rtn_i),
        .paid (paid),
        .owed (owed)
    );

    // An ack only counts once our request is actually on the line.
    always_comb begin
        ack_take = bus.hopper_ack &&
                   (((state_q == StEject1) && eject1_q) || ((state_q == StEject2) && eject2_q));
        paid = 2'd0;
        if (ack_take) paid = (state_q == StEject2) ? 2'(COIN2_VAL) : 2'(COIN1_VAL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            fault_q  <= FLT_NONE;
            eject1_q <= 1'b0;
            eject2_q <= 1'b0;
            c1_q     <= INIT1;
            c2_q     <= INIT2;
            tmo_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (owed != 4'd0) state_q <= StSelect;
                end
                StSelect: begin
                    if (owed == 4'd0) begin
                        state_q <= StIdle;
                    end else if (owed >= 4'(COIN2_VAL) && c2_q != '0) begin
                        state_q <= StEject2;
                    end else if (c1_q != '0) begin
                        state_q <= StEject1;
                    end else begin
                        state_q <= StFaultEmpty;
                        fault_q <= FLT_EMPTY;
                    end
                end
                StEject1, StEject2: begin
                    if (!eject1_q && !eject2_q) begin
                        eject1_q <= (state_q == StEject1);
                        eject2_q <= (state_q == StEject2);
                        tmo_q    <= '0;
                    end else if (ack_take) begin
                        eject1_q <= 1'b0;
                        eject2_q <= 1'b0;
                        if (state_q == StEject1) begin
                            if (c1_q != '0) c1_q <= c1_q - CNT_W'(1);
                        end else begin
                            if (c2_q != '0) c2_q <= c2_q - CNT_W'(1);
                        end
                        state_q <= StWaitRel;
                    end else if (tmo_q == TMO_LAST) begin
                        eject1_q <= 1'b0;
                        eject2_q <= 1'b0;
                        fault_q  <= FLT_TIMEOUT;
                        state_q  <= StFaultTo;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                StWaitRel: begin
                    if (!bus.hopper_ack) state_q <= StSelect;
                end
                StFaultEmpty: begin
                    if (bus.refill) begin
                        fault_q <= FLT_NONE;
                        state_q <= StSelect;
                    end
                end
                StFaultTo: begin
                    if (bus.clear_fault) begin
                        fault_q <= FLT_NONE;
                        state_q <= StSelect;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Placed last so a restock overrides a same-cycle coin decrement.
            if (bus.refill) begin
                c1_q <= INIT1;
                c2_q <= INIT2;
            end
        end
    end

    assign bus.eject1   = eject1_q;
    assign bus.eject2   = eject2_q;
    assign bus.busy     = (owed != 4'd0) || (state_q != StIdle);
    assign bus.owed     = owed;
    assign bus.fault    = fault_q;
    assign bus.c1_level = c1_q;
    assign bus.c2_level = c2_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised and directed bench for change_dispenser against a coin-level reference model.
module tb_change_dispenser;

    localparam int unsigned CNT_W       = 8;
    localparam int          INIT_C1     = 20;
    localparam int          INIT_C2     = 20;
    localparam int          ACK_TIMEOUT = 64;

    logic clk;
    logic rst;

    change_dispenser_if #(.CNT_W(CNT_W)) dif ();

    change_dispenser #(
        .CNT_W       (CNT_W),
        .INIT_C1     (INIT_C1),
        .INIT_C2     (INIT_C2),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owed amount, tube contents, coins dropped so far.
    int m_owed, m_c1, m_c2, t_c1, t_c2;
    int pdt_prev, rtn_prev, e1_prev, e2_prev;
    int h_owed[2];
    int h_c2[2];
    int added, paid;
    bit mon_en    = 1'b0;
    bit hop_en    = 1'b1;
    int hop_delay = 2;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        m_owed = 0; m_c1 = INIT_C1; m_c2 = INIT_C2;
        pdt_prev = 0; rtn_prev = 0; e1_prev = 0; e2_prev = 0;
        h_owed = '{0, 0};
        h_c2 = '{0, 0};
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        tick();
        tick();
        while ((dif.busy || dif.hopper_ack) && n < 3000) begin
            tick();
            n++;
        end
        check_eq(tag, int'(dif.busy), 0);
    endtask

    task automatic wait_eject2(input string tag);
        int n = 0;
        while (!dif.eject2 && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, int'(dif.eject2), 1);
    endtask

    task automatic pulse_change(input int amt);
        dif.pdt_i = 1'b1;
        dif.cng_i = 3'(amt);
        tick();
        dif.pdt_i = 1'b0;
        dif.cng_i = 3'd0;
    endtask

    task automatic pulse_refund(input int amt);
        dif.rtn_i = 3'(amt);
        tick();
        dif.rtn_i = 3'd0;
    endtask

    task automatic pulse_refill();
        dif.refill = 1'b1;
        tick();
        dif.refill = 1'b0;
    endtask

    // Hopper: acknowledges each request after a programmable or random delay.
    initial begin : hopper
        int d, h;
        dif.hopper_ack = 1'b0;
        forever begin
            tick();
            if (hop_en && rst && (dif.eject1 || dif.eject2)) begin
                d = (hop_delay < 0) ? int'($urandom_range(0, 3)) : hop_delay;
                repeat (d) tick();
                dif.hopper_ack = 1'b1;
                h = int'($urandom_range(1, 2));
                repeat (h) tick();
                dif.hopper_ack = 1'b0;
            end
        end
    end

    // Per-cycle model step, sampled mid-cycle while inputs and outputs are stable.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("owed", int'(dif.owed), m_owed);
            check_eq("c1_level", int'(dif.c1_level), m_c1);
            check_eq("c2_level", int'(dif.c2_level), m_c2);
            check_eq("eject_exclusive", int'(dif.eject1 & dif.eject2), 0);
            // Coin choice was made in SELECT, two samples before the request appears.
            if ((dif.eject1 && e1_prev == 0) || (dif.eject2 && e2_prev == 0))
                check_eq("coin_choice", int'(dif.eject2), int'(h_owed[1] >= 2 && h_c2[1] > 0));
            h_owed[1] = h_owed[0]; h_owed[0] = m_owed;
            h_c2[1]   = h_c2[0];   h_c2[0]   = m_c2;
            e1_prev = int'(dif.eject1);
            e2_prev = int'(dif.eject2);
            added = 0;
            if (dif.pdt_i && pdt_prev == 0 && dif.cng_i != 3'd0) added += int'(dif.cng_i);
            if (dif.rtn_i != 3'd0 && rtn_prev == 0) added += int'(dif.rtn_i);
            paid = 0;
            if (dif.hopper_ack && dif.eject1) paid = 1;
            if (dif.hopper_ack && dif.eject2) paid = 2;
            m_owed = m_owed - paid + added;
            if (m_owed > 15) m_owed = 15;
            if (paid == 1) t_c1++;
            if (paid == 2) t_c2++;
            if (dif.refill) begin
                m_c1 = INIT_C1;
                m_c2 = INIT_C2;
            end else begin
                if (paid == 1) m_c1--;
                if (paid == 2) m_c2--;
            end
            pdt_prev = int'(dif.pdt_i);
            rtn_prev = (dif.rtn_i != 3'd0) ? 1 : 0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b1, b2, n;
        dif.pdt_i = 1'b0; dif.cng_i = 3'd0; dif.rtn_i = 3'd0;
        dif.refill = 1'b0; dif.clear_fault = 1'b0;
        t_c1 = 0; t_c2 = 0;
        rst = 1'b0;
        repeat (3) tick();
        check_eq("rst_owed", int'(dif.owed), 0);
        check_eq("rst_busy", int'(dif.busy), 0);
        check_eq("rst_fault", int'(dif.fault), 0);
        check_eq("rst_eject", int'(dif.eject1 | dif.eject2), 0);
        check_eq("rst_c1", int'(dif.c1_level), INIT_C1);
        check_eq("rst_c2", int'(dif.c2_level), INIT_C2);
        rst = 1'b1;
        reset_model();
        mon_en = 1'b1;
        tick();

        // Change of 3: one value-2 then one value-1 coin.
        b1 = t_c1; b2 = t_c2;
        pulse_change(3);
        wait_idle("chg_idle");
        check_eq("chg_coin2", t_c2 - b2, 1);
        check_eq("chg_coin1", t_c1 - b1, 1);
        check_eq("chg_c2", int'(dif.c2_level), 19);
        check_eq("chg_c1", int'(dif.c1_level), 19);

        // Refund 5, second refund of 2 during payout: total 7 = 3x2 + 1x1.
        b1 = t_c1; b2 = t_c2;
        pulse_refund(5);
        n = 0;
        while (t_c2 == b2 && n < 100) begin tick(); n++; end
        check_eq("rfd_first_coin", t_c2 - b2, 1);
        pulse_refund(2);
        wait_idle("rfd_idle");
        check_eq("rfd_coin2", t_c2 - b2, 3);
        check_eq("rfd_coin1", t_c1 - b1, 1);
        check_eq("rfd_owed", int'(dif.owed), 0);

        // Saturation: 7+7 then another 7 before any coin is paid.
        hop_delay = -1;
        b1 = t_c1; b2 = t_c2;
        dif.pdt_i = 1'b1; dif.cng_i = 3'd7; dif.rtn_i = 3'd7;
        tick();
        dif.pdt_i = 1'b0; dif.cng_i = 3'd0; dif.rtn_i = 3'd0;
        tick();
        dif.rtn_i = 3'd7;
        tick();
        dif.rtn_i = 3'd0;
        check_eq("sat_owed", int'(dif.owed), 15);
        wait_idle("sat_idle");
        check_eq("sat_coin2", t_c2 - b2, 7);
        check_eq("sat_coin1", t_c1 - b1, 1);

        // Random traffic with random hopper latency and occasional restocks.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: pulse_change(int'($urandom_range(0, 7)));
                4, 5, 6:    pulse_refund(int'($urandom_range(1, 7)));
                7: begin
                    dif.pdt_i = 1'b1;
                    dif.cng_i = 3'($urandom_range(1, 7));
                    dif.rtn_i = 3'($urandom_range(1, 7));
                    tick();
                    dif.pdt_i = 1'b0; dif.cng_i = 3'd0; dif.rtn_i = 3'd0;
                end
                8:       pulse_refill();
                default: tick();
            endcase
            repeat ($urandom_range(0, 12)) tick();
        end
        pulse_refill();
        wait_idle("rand_idle");
        check_eq("rand_owed", int'(dif.owed), 0);

        // Drain tube 2, then a change of 4 must come out as four value-1 coins.
        pulse_refill();
        for (int i = 0; i < 6; i++) begin
            pulse_refund(6);
            wait_idle("drain2_idle");
        end
        pulse_refund(4);
        wait_idle("drain2_idle");
        check_eq("drain2_c2", int'(dif.c2_level), 0);
        b1 = t_c1; b2 = t_c2;
        pulse_change(4);
        wait_idle("only1_idle");
        check_eq("only1_coin1", t_c1 - b1, 4);
        check_eq("only1_coin2", t_c2 - b2, 0);
        check_eq("only1_c1", int'(dif.c1_level), INIT_C1 - 4);

        // Drain tube 1 as well, then owe 3 with both tubes empty.
        pulse_refund(7);
        wait_idle("drain1_idle");
        pulse_refund(7);
        wait_idle("drain1_idle");
        pulse_refund(2);
        wait_idle("drain1_idle");
        check_eq("drain1_c1", int'(dif.c1_level), 0);
        b1 = t_c1; b2 = t_c2;
        pulse_refund(3);
        repeat (10) tick();
        check_eq("empty_fault", int'(dif.fault), 1);
        check_eq("empty_owed", int'(dif.owed), 3);
        check_eq("empty_no_eject", int'(dif.eject1 | dif.eject2), 0);
        check_eq("empty_no_coin", (t_c1 - b1) + (t_c2 - b2), 0);
        pulse_refill();
        check_eq("refill_fault", int'(dif.fault), 0);
        wait_idle("refill_idle");
        check_eq("refill_coin2", t_c2 - b2, 1);
        check_eq("refill_coin1", t_c1 - b1, 1);
        check_eq("refill_c1", int'(dif.c1_level), INIT_C1 - 1);
        check_eq("refill_c2", int'(dif.c2_level), INIT_C2 - 1);

        // Hopper never answers: request must last exactly ACK_TIMEOUT cycles.
        hop_en = 1'b0;
        b2 = t_c2;
        pulse_refund(2);
        wait_eject2("to_request");
        n = 0;
        while (dif.eject2 && n < 200) begin tick(); n++; end
        check_eq("to_req_cycles", n, ACK_TIMEOUT);
        check_eq("to_fault", int'(dif.fault), 2);
        check_eq("to_owed", int'(dif.owed), 2);
        check_eq("to_c2", int'(dif.c2_level), INIT_C2 - 1);
        check_eq("to_c1", int'(dif.c1_level), INIT_C1 - 1);
        repeat (5) tick();
        check_eq("to_held", int'(dif.eject1 | dif.eject2), 0);
        check_eq("to_fault_held", int'(dif.fault), 2);
        hop_en = 1'b1;
        hop_delay = 1;
        dif.clear_fault = 1'b1;
        tick();
        dif.clear_fault = 1'b0;
        check_eq("clr_fault", int'(dif.fault), 0);
        wait_eject2("retry_eject2");
        wait_idle("retry_idle");
        check_eq("retry_coin2", t_c2 - b2, 1);
        check_eq("retry_c2", int'(dif.c2_level), INIT_C2 - 2);

        // Asynchronous reset while a value-2 request is outstanding.
        hop_en = 1'b0;
        pulse_refund(4);
        wait_eject2("arst_request");
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("arst_eject2", int'(dif.eject2), 0);
        check_eq("arst_eject1", int'(dif.eject1), 0);
        check_eq("arst_owed", int'(dif.owed), 0);
        check_eq("arst_busy", int'(dif.busy), 0);
        check_eq("arst_fault", int'(dif.fault), 0);
        check_eq("arst_c1", int'(dif.c1_level), INIT_C1);
        check_eq("arst_c2", int'(dif.c2_level), INIT_C2);
        tick();
        tick();
        rst = 1'b1;
        reset_model();
        mon_en = 1'b1;
        hop_en = 1'b1;
        repeat (5) tick();
        check_eq("post_rst_busy", int'(dif.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending FSM. Consumes its pdt/cng (change after a sale) and rtn (refund after cancel) outputs.
- Physically pays the owed amount as value-1 and value-2 coins through a two-tube coin hopper, using a request/acknowledge handshake per coin.
- Tracks tube inventories, queues new amounts that arrive while busy, and flags empty-tube and hopper-timeout faults.

Parameters:
- CNT_W, 8, width of each tube inventory counter.
- INIT_C1, 20, value-1 coins loaded into tube 1 on reset/refill.
- INIT_C2, 20, value-2 coins loaded into tube 2 on reset/refill.
- ACK_TIMEOUT, 64, cycles allowed for hopper_ack after an eject request.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- pdt_i  in  1  product-released flag from the vending FSM.
- cng_i  in  3  change amount, valid while pdt_i=1.
- rtn_i  in  3  refund amount from the vending FSM.
- hopper_ack  in  1  hopper acknowledge; one coin has dropped.
- refill  in  1  one-cycle pulse; both tubes restocked to INIT values.
- clear_fault  in  1  one-cycle pulse; leave timeout fault.
- eject1  out  1  request to drop one value-1 coin.
- eject2  out  1  request to drop one value-2 coin.
- busy  out  1  owed amount is non-zero or a handshake is in progress.
- owed  out  4  amount still to pay.
- fault  out  2  00 none, 01 tubes empty, 10 hopper timeout.
- c1_level  out  CNT_W  tube-1 inventory.
- c2_level  out  CNT_W  tube-2 inventory.

Behaviour:
- Reset (rst=0, async): state IDLE; eject1=eject2=0; busy=0; owed=0; fault=00; c1_level=INIT_C1; c2_level=INIT_C2; edge registers=0; timeout counter=0.
- Event capture (every state):
  - Change event: rising edge of pdt_i with cng_i≠0 adds cng_i.
  - Refund event: rtn_i goes from 0 to non-zero, which adds rtn_i.
  - Both events in the same cycle add both.
  - owed saturates at 15.
  - A payout decrement in the same cycle combines with the addition: owed_next = sat(owed − paid + added).
- States:
  - IDLE: busy=0. If owed≠0 → SELECT.
  - SELECT, coin choice:
    - owed≥2 and c2_level>0 → EJECT2.
    - else c1_level>0 → EJECT1.
    - else owed≥2 and c2_level=0 and c1_level=0 → FAULT_EMPTY.
    - owed=1 and c1_level=0 → FAULT_EMPTY. A value-2 coin is never used to overpay.
    - owed=0 → IDLE.
  - EJECT1/EJECT2:
    - The matching eject line is asserted the cycle after entry and held.
    - On the first cycle with hopper_ack=1: drop eject, decrement the level by 1, decrement owed by 1 or 2, → WAIT_REL.
    - If ACK_TIMEOUT cycles elapse without ack: drop eject, no decrement, fault=10, → FAULT_TO.
  - WAIT_REL: wait for hopper_ack=0, then → SELECT. A new request is never issued while ack is high.
  - FAULT_EMPTY: fault=01, eject low, owed retained. On refill → fault=00, → SELECT.
  - FAULT_TO: fault=10, eject low. On clear_fault → fault=00, → SELECT and retry the same coin choice.
- refill is honoured in any state. It reloads both levels. If it coincides with an ack decrement, the reload wins.
- At most one eject line is high at any time.
- Minimum time per coin with ack returned immediately: SELECT→EJECT (1), request (1), ack (1), release (1), i.e. 4 cycles.
- A level counter never underflows. A decrement is impossible at 0 by construction.

Decomposition:
- Shared package vending_pkg:
  - state enum for this block;
  - fault codes FLT_NONE/FLT_EMPTY/FLT_TIMEOUT;
  - coin values COIN1_VAL=1, COIN2_VAL=2.
- One sub-module, dispense_event_capture: edge detection on pdt_i/rtn_i and the saturating owed accumulator with decrement input.
- The FSM, level counters and timeout counter live in the top.

Test Plan:
- Change: pdt_i rises with cng_i=3, ack returns 2 cycles after each request → eject2 then eject1. owed 3→1→0, c2_level=19, c1_level=19, busy drops after the last release.
- Refund: rtn_i 0→5, then cancel again during payout with rtn_i 0→2 → owed peaks at 7 (5+2, minus coins paid so far). Total coins: value-2 ×3, value-1 ×1, matching 7. owed ends 0.
- Empty tube 2: reset with c2 tube drained by prior payouts, cng_i=4 → four eject1 pulses and c1_level −4.
- Both tubes empty, owed=3 → fault=01, owed stays 3, no eject. refill pulse → fault=00 and payout completes.
- Timeout: hopper_ack held 0 → eject2 drops after exactly ACK_TIMEOUT cycles, fault=10, levels unchanged. clear_fault → same eject2 reissued.
- Async reset mid-EJECT with eject2=1 → eject2=0 immediately without clock; owed=0, levels back to INIT values.
